// File: rtl/vga_arb_pkg.sv
// Shared types, default geometry and the scan-address helper for the VGA framebuffer arbiter.
package vga_arb_pkg;

    localparam int ARB_ADDR_W     = 19;
    localparam int ARB_DATA_W     = 8;
    localparam int ARB_H_ACTIVE   = 640;
    localparam int ARB_V_ACTIVE   = 480;
    localparam int ARB_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // v*640 + h as shifts and adds; 20 bits covers the largest visible address.
    function automatic logic [19:0] scan_addr(input logic [9:0] h, input logic [8:0] v);
        logic [19:0] w_v;
        w_v = {11'd0, v};
        return (w_v << 9) + (w_v << 7) + {10'd0, h};
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Host write FIFO: synchronous, power-of-two depth, async active-low reset.
module vga_wr_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_cnt;
    logic             r_full;
    logic [PW:0]      w_cnt_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_cnt != '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    // Full resets high so the host sees wr_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b1;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between VGA scanout and buffered host writes.
// Optional VGA_ARB_STATS_EN adds stall_cnt (host cycles blocked by a full FIFO, per frame).
module vga_fb_arbiter
    import vga_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int H_ACTIVE   = ARB_H_ACTIVE,
    parameter int V_ACTIVE   = ARB_V_ACTIVE,
    parameter int FIFO_DEPTH = ARB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        HCount,
    input  logic [8:0]        VCount,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel
`ifdef VGA_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_t         r_state;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_vld_data;
    logic [DATA_W-1:0]  r_pixel;

    logic               w_window;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_window = (HCount < 10'(H_ACTIVE)) && (VCount < 9'(V_ACTIVE));
    assign w_pop    = !w_window && !w_empty;
    assign wr_ready = !w_full;

    vga_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (wr_valid && wr_ready),
        .i_wdata ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_rdata ({w_head_addr, w_head_data}),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State SCAN marks the request cycle; r_vld_data marks the data cycle; r_pixel is the third stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vld_data  <= 1'b0;
            r_pixel     <= '0;
        end else begin
            r_vld_data <= (r_state == SCAN);
            r_pixel    <= r_vld_data ? mem_rdata : '0;
            if (w_window) begin
                r_state    <= SCAN;
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= ADDR_W'(scan_addr(HCount, VCount));
            end else if (!w_empty) begin
                r_state     <= DRAIN;
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_head_addr;
                r_mem_wdata <= w_head_data;
            end else begin
                r_state  <= IDLE;
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pixel     = r_pixel;

`ifdef VGA_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if ((HCount == '0) && (VCount == '0))
            r_stall_cnt <= '0;
        else if (wr_valid && !wr_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a transaction-level model of the arbitration rules.
module tb_vga_fb_arbiter;

    localparam int NWORDS = 307200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h;
    logic [8:0]  v;
    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  pixel;
`ifdef VGA_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .HCount    (h),
        .VCount    (v),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pixel     (pixel)
`ifdef VGA_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] ram    [NWORDS];
    logic [7:0] shadow [NWORDS];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    wr_t         q[$];
    bit          m_ready;
    bit          m_en;
    bit          m_we;
    int          m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  pipe0, pipe1, m_pixel;
    int          m_stall;
    bit          pend_v;
    wr_t         pend;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, obs, exp, h, v, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ready = 0; m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        pipe0 = 0; pipe1 = 0; m_pixel = 0; m_stall = 0; pend_v = 0;
    endtask

    // Model of one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit  win;
        int  a;
        wr_t e;
        if (pend_v) shadow[pend.a] = pend.d;
        pend_v = 0;
        win = (int'(h) < 640) && (int'(v) < 480);
        m_pixel = pipe1;
        pipe1 = pipe0;
        if (h == 0 && v == 0) m_stall = 0;
        else if (wr_valid && !m_ready && m_stall < 65535) m_stall++;
        if (win) begin
            a = int'(v) * 640 + int'(h);
            m_en = 1; m_we = 0; m_addr = a;
            pipe0 = shadow[a];
        end else begin
            pipe0 = 0;
            if (q.size() > 0) begin
                e = q.pop_front();
                m_en = 1; m_we = 1; m_addr = int'(e.a); m_wdata = e.d;
                pend = e; pend_v = 1;
            end else begin
                m_en = 0; m_we = 0;
            end
        end
        if (wr_valid && m_ready) begin
            e.a = wr_addr; e.d = wr_data;
            q.push_back(e);
        end
        m_ready = (q.size() < 4);
    endtask

    task automatic check_outputs();
        check_val("wr_ready", wr_ready, m_ready);
        check_val("mem_en", mem_en, m_en);
        if (m_en) begin
            check_val("mem_we", mem_we, m_we);
            check_val("mem_addr", mem_addr, m_addr);
            if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
        end
        check_val("pixel", pixel, m_pixel);
`ifdef VGA_ARB_STATS_EN
        check_val("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic adv_counts();
        if (h == 10'd799) begin
            h = 0;
            v = (v == 9'd524) ? 9'd0 : v + 9'd1;
        end else begin
            h = h + 10'd1;
        end
    endtask

    task automatic rand_write();
        wr_addr = 19'($urandom_range(0, 2047));
        wr_data = 8'($urandom);
    endtask

    task automatic push_n(input int n);
        wr_valid = 1;
        for (int i = 0; i < n; i++) begin
            rand_write();
            step();
        end
        wr_valid = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            adv_counts();
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            ram[i]    = i[7:0];
            shadow[i] = i[7:0];
        end
        rst_n = 0; h = 0; v = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", wr_ready, 0);
        check_val("rst_en", mem_en, 0);
        check_val("rst_we", mem_we, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_pixel", pixel, 0);
        rst_n = 1;

        step();
        check_val("t1_ready_after_edge", wr_ready, 1);
        check_val("t1_first_addr", mem_addr, 0);
        h = 5; v = 2;
        step();
        check_val("t2_addr", mem_addr, 1285);
        h = 6; step();
        h = 7; step();
        check_val("t2_pixel", pixel, 8'h05);

        // Fill the FIFO inside the window, then let it drain at the blanking edge.
        h = 100; v = 10;
        push_n(4);
        check_val("t3_full_ready", wr_ready, 0);
        h = 630;
        run(20);

        h = 100; v = 10; push_n(3);
        h = 798; v = 479; run(8);

        h = 100; v = 4; push_n(3);
        h = 798; v = 5; run(6);
        h = 640; v = 6; run(4);

        // Full FIFO with a held request while draining.
        h = 100; v = 10; push_n(4);
        h = 700; wr_valid = 1;
        for (int i = 0; i < 8; i++) begin
            rand_write();
            step();
            adv_counts();
        end
        wr_valid = 0;
        run(6);

        // Reset in the middle of a drain.
        h = 100; v = 10; push_n(3);
        h = 700; step();
        rst_n = 0;
        #1;
        check_val("rstmid_en", mem_en, 0);
        check_val("rstmid_ready", wr_ready, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
        run(6);

`ifdef VGA_ARB_STATS_EN
        h = 100; v = 10; push_n(4);
        wr_valid = 1;
        for (int i = 0; i < 10; i++) step();
        wr_valid = 0;
        h = 799; v = 524; run(3);
`endif

        for (int s = 0; s < 60; s++) begin
            int sel, p;
            sel = $urandom % 4;
            p   = $urandom_range(1, 9);
            case (sel)
                0: begin h = 10'($urandom_range(0, 799)); v = 9'($urandom_range(0, 524)); end
                1: begin h = 10'($urandom_range(630, 639)); v = 9'($urandom_range(0, 3)); end
                2: begin h = 10'($urandom_range(785, 799)); v = ($urandom % 2) ? 9'd479 : 9'd524; end
                default: begin h = 10'($urandom_range(0, 20)); v = 9'($urandom_range(0, 3)); end
            endcase
            for (int i = 0; i < 30; i++) begin
                wr_valid = (($urandom % 10) < p);
                rand_write();
                step();
                adv_counts();
            end
        end
        wr_valid = 0;
        h = 700; v = 500;
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
